// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
// The full-subtractor cell equations are documented here for reference.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Full-subtractor cell:
  //   diff = a ^ b ^ bin
  //   bout = (~a & b) | (~(a ^ b) & bin)

  // Bit-counter width; at least one bit even for the smallest legal WIDTH.
  function automatic int count_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single combinational full-subtractor cell: one difference bit plus borrow-out.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {b_out,d} = a - b - b_in, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = count_w(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_b_out;

  logic             w_diff;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  full_subtractor u_cell (
    .diff (w_diff),
    .bout (w_bout),
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow)
  );

  assign w_last = (r_count == CW'(WIDTH - 1));
  // Result as it will stand once the current bit lands in the MSB slot.
  assign w_res  = {w_diff, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_b_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= b_in;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res;
          r_borrow <= w_bout;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_d     <= w_res;
            r_b_out <= w_bout;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs survive the shift-out so overflow can be judged at completion.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state != S_RUN) begin
      if (start) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign d     = r_d;
  assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a cycle-level behavioural model.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a countdown of remaining cycles and the arithmetic result.
  int           rem = 0;
  bit           m_valid = 1'b0;
  logic         m_busy, m_done, m_bo, m_ovf;
  logic [W-1:0] m_d;
  logic [W:0]   pend;
  logic         pend_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      rem = 0;
      m_busy = 1'b0; m_done = 1'b0; m_d = '0; m_bo = 1'b0; m_ovf = 1'b0;
    end else if (m_valid) begin
      if (rem == 0) begin
        m_done = 1'b0;
        if (start) begin
          pend = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, b_in};
          pend_ovf = (a[W-1] != b[W-1]) && (pend[W-1] != a[W-1]);
          rem = W;
          m_busy = 1'b1;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_d = pend[W-1:0];
          m_bo = pend[W];
          m_ovf = pend_ovf;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_d", d, m_d);
      check("cyc_b_out", b_out, m_bo);
`ifdef SERIAL_SUB_OVF_EN
      check("cyc_ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and return cycles from the accept edge to done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        output int lat);
    start = 1'b1; a = ia; b = ib; b_in = ibin;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= W + 4; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int first;
    logic [W-1:0] cap_d;
    logic cap_bo;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_b_out", b_out, 0);
    rst = 1'b0;
    tick();

    // 7 - 3
    run_op(4'b0111, 4'b0011, 1'b0, lat);
    check("t1_lat", lat, 4);
    check("t1_d", d, 4'b0100);
    check("t1_b_out", b_out, 0);
    repeat (2) tick();

    // 3 - 7 wraps with borrow
    run_op(4'b0011, 4'b0111, 1'b0, lat);
    check("t2_d", d, 4'b1100);
    check("t2_b_out", b_out, 1);

    // Borrow-in only, then back-to-back start straight out of DONE
    run_op(4'd0, 4'd0, 1'b1, lat);
    check("t3a_d", d, 4'b1111);
    check("t3a_b_out", b_out, 1);
    run_op(4'd9, 4'd4, 1'b0, lat);
    check("t3b_lat", lat, 4);
    check("t3b_d", d, 4'd5);
    check("t3b_b_out", b_out, 0);
    repeat (2) tick();

    // Start during RUN is ignored
    start = 1'b1; a = 4'd6; b = 4'd1; b_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'd0; b = 4'd15;
    tick();
    start = 1'b0;
    pulses = 0; first = -1; cap_d = '0; cap_bo = 1'b0;
    for (int n = 3; n <= 12; n++) begin
      tick();
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = n; cap_d = d; cap_bo = b_out;
        end
      end
    end
    check("t4_lat", first, 4);
    check("t4_pulses", pulses, 1);
    check("t4_d", cap_d, 4'd5);
    check("t4_b_out", cap_bo, 0);

    // Reset mid-RUN aborts
    start = 1'b1; a = 4'd5; b = 4'd2; b_in = 1'b0;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_d", d, 0);
    check("t5_b_out", b_out, 0);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    run_op(4'd12, 4'd5, 1'b0, lat);
    check("t5_lat", lat, 4);
    check("t5_d2", d, 4'd7);
    check("t5_b_out2", b_out, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'b1000, 4'b0001, 1'b0, lat);
    check("t6a_d", d, 4'b0111);
    check("t6a_ovf", ovf, 1);
    run_op(4'b0101, 4'b0010, 1'b0, lat);
    check("t6b_ovf", ovf, 0);
`endif

    // Exhaustive operand sweep with random start noise, gaps and occasional aborts
    for (int ai = 0; ai < (1 << W); ai++) begin
      for (int bi = 0; bi < (1 << W); bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic seen;
          logic aborted;
          start = 1'b1; a = W'(ai); b = W'(bi); b_in = ci[0];
          tick();
          seen = 1'b0; aborted = 1'b0;
          for (int n = 0; n < W + 4; n++) begin
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
            if ($urandom_range(0, 150) == 0) begin
              start = 1'b0;
              rst = 1'b1;
              tick();
              rst = 1'b0;
              aborted = 1'b1;
              break;
            end
            tick();
            if (done) begin
              seen = 1'b1;
              break;
            end
          end
          start = 1'b0;
          if (!aborted) check("sweep_done_seen", seen, 1);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
